decode_ctrl_stage: RTL and testbench

Parametrised successor to the combinational opcode decoder. Decodes the full instruction (opcode, funct3, funct7) and flags illegal encodings, then registers the complete control bundle into the ID/EX boundary. A valid/ready handshake carries the bundle, with flush support and an optional halt-on-illegal state machine. Sits between the IF/ID register and the execute stage; the hazard unit drives the flush.

---
 rtl/riscv_pkg.sv | 54 +++++
 rtl/instr_decode_comb.sv | 117 +++++++++++
 rtl/decode_ctrl_stage.sv | 120 ++++++++++++
 tb/tb_decode_ctrl_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, control encodings, the ID/EX control bundle and stage FSM states.
// Pure declarations, no timing or handshake.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALUOP_LDST = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_RI   = 2'b10;

  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [1:0] alu_op;
    logic [1:0] alu_src_a;
    logic       mul_div;
    logic       illegal;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_bundle_t;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} stage_state_e;

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational RV32I(+M) decoder: instruction word to control bundle with illegal flag. Zero latency.
// No handshake; illegal encodings have all architectural side-effect controls forced off.
import riscv_pkg::*;

module instr_decode_comb #(
  parameter int unsigned EN_MEXT = 0
) (
  input  logic [31:0]  i_instr,
  output ctrl_bundle_t o_ctrl
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign opcode = i_instr[6:0];
  assign f3     = i_instr[14:12];
  assign f7     = i_instr[31:25];

  always_comb begin
    o_ctrl          = '0;
    legal           = 1'b0;
    o_ctrl.funct3   = f3;
    o_ctrl.funct7b5 = i_instr[30];
    o_ctrl.rd       = i_instr[11:7];
    o_ctrl.rs1      = i_instr[19:15];
    o_ctrl.rs2      = i_instr[24:20];

    case (opcode)
      OP_LOAD: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.result_src = RES_MEM;
        o_ctrl.imm_src    = IMM_I;
        o_ctrl.alu_op     = ALUOP_LDST;
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OP_STORE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_S;
        o_ctrl.alu_op    = ALUOP_LDST;
        legal = f3 inside {3'b000, 3'b001, 3'b010};
      end
      OP_BRANCH: begin
        o_ctrl.branch  = 1'b1;
        o_ctrl.imm_src = IMM_B;
        o_ctrl.alu_op  = ALUOP_BR;
        legal = !(f3 inside {3'b010, 3'b011});
      end
      OP_JALR: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jump       = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.imm_src    = IMM_I;
        legal = (f3 == 3'b000);
      end
      OP_JAL: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.jump       = 1'b1;
        o_ctrl.result_src = RES_PC4;
        o_ctrl.imm_src    = IMM_J;
        legal = 1'b1;
      end
      OP_R_TYPE: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_op    = ALUOP_RI;
        case (f7)
          7'b0000000: legal = 1'b1;
          7'b0100000: legal = f3 inside {3'b000, 3'b101};
          7'b0000001: begin
            legal          = (EN_MEXT != 0);
            o_ctrl.mul_div = 1'b1;
          end
          default:    legal = 1'b0;
        endcase
      end
      OP_I_TYPE: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_I;
        o_ctrl.alu_op    = ALUOP_RI;
        // Shift-immediates reuse funct7 as the upper shamt field, which must be clean on RV32.
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
      end
      OP_LUI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_U;
        o_ctrl.alu_src_a = SRCA_ZERO;
        legal = 1'b1;
      end
      OP_AUIPC: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.imm_src   = IMM_U;
        o_ctrl.alu_src_a = SRCA_PC;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      o_ctrl.reg_write = 1'b0;
      o_ctrl.mem_write = 1'b0;
      o_ctrl.branch    = 1'b0;
      o_ctrl.jump      = 1'b0;
      o_ctrl.mul_div   = 1'b0;
    end
    o_ctrl.illegal = !legal;
  end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Decode stage: registers the decoded control bundle into ID/EX with 1-cycle latency.
// Valid/ready: holds the bundle while execute stalls; flush squashes it and clears a halt-on-illegal stop.
import riscv_pkg::*;

module decode_ctrl_stage #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned EN_MEXT         = 0,
  parameter int unsigned HALT_ON_ILLEGAL = 1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic             o_valid,
  output logic             o_RegWrite,
  output logic             o_MemWrite,
  output logic             o_Branch,
  output logic             o_Jump,
  output logic             o_ALUSrc,
  output logic [1:0]       o_ResultSrc,
  output logic [2:0]       o_ImmSrc,
  output logic [1:0]       o_ALUOp,
  output logic [1:0]       o_ALUSrcA,
  output logic             o_MulDiv,
  output logic [2:0]       o_funct3,
  output logic             o_funct7b5,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [XLEN-1:0]  o_pc,
  output logic             o_illegal,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  ctrl_bundle_t     dec_ctrl;
  ctrl_bundle_t     bundle_d, bundle_q;
  logic [XLEN-1:0]  pc_d, pc_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  stage_state_e     state_d, state_q;
  logic             accept;

  instr_decode_comb #(.EN_MEXT(EN_MEXT)) u_dec (
    .i_instr (i_instr),
    .o_ctrl  (dec_ctrl)
  );

  assign o_ready = (state_q == RUN) && (!valid_q || i_ready);
  assign accept  = i_valid && o_ready;

  always_comb begin
    bundle_d = bundle_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    state_d  = state_q;

    if (i_flush) begin
      valid_d  = 1'b0;
      bundle_d = '0;
      state_d  = RUN;
    end else if (accept) begin
      valid_d  = 1'b1;
      bundle_d = dec_ctrl;
      pc_d     = i_pc;
      // Writes to x0 are architecturally discarded; drop them here so execute never sees one.
      if (dec_ctrl.rd == 5'd0) bundle_d.reg_write = 1'b0;
      if (dec_ctrl.illegal) begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (HALT_ON_ILLEGAL != 0) state_d = HALT;
      end
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bundle_q <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      state_q  <= RUN;
    end else begin
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_RegWrite    = bundle_q.reg_write;
  assign o_MemWrite    = bundle_q.mem_write;
  assign o_Branch      = bundle_q.branch;
  assign o_Jump        = bundle_q.jump;
  assign o_ALUSrc      = bundle_q.alu_src;
  assign o_ResultSrc   = bundle_q.result_src;
  assign o_ImmSrc      = bundle_q.imm_src;
  assign o_ALUOp       = bundle_q.alu_op;
  assign o_ALUSrcA     = bundle_q.alu_src_a;
  assign o_MulDiv      = bundle_q.mul_div;
  assign o_funct3      = bundle_q.funct3;
  assign o_funct7b5    = bundle_q.funct7b5;
  assign o_rd          = bundle_q.rd;
  assign o_rs1         = bundle_q.rs1;
  assign o_rs2         = bundle_q.rs2;
  assign o_pc          = pc_q;
  assign o_illegal     = bundle_q.illegal;
  assign o_halted      = (state_q == HALT);
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: three configurations share one stimulus stream.
// Instance 0 = defaults, 1 = RV32M enabled, 2 = no halt with a 2-bit counter.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        ready_in;
  logic        flush;

  logic        o_ready[3], o_valid[3], reg_write[3], mem_write[3], branch[3], jump[3], alu_src[3];
  logic [1:0]  result_src[3], alu_op[3], alu_src_a[3];
  logic [2:0]  imm_src[3], funct3[3];
  logic        mul_div[3], funct7b5[3], illegal[3], halted[3];
  logic [4:0]  rd[3], rs1[3], rs2[3];
  logic [31:0] pc_out[3];
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decode_ctrl_stage u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in), .o_ready(o_ready[0]), .i_instr(instr),
    .i_pc(pc), .i_ready(ready_in), .i_flush(flush), .o_valid(o_valid[0]),
    .o_RegWrite(reg_write[0]), .o_MemWrite(mem_write[0]), .o_Branch(branch[0]), .o_Jump(jump[0]),
    .o_ALUSrc(alu_src[0]), .o_ResultSrc(result_src[0]), .o_ImmSrc(imm_src[0]), .o_ALUOp(alu_op[0]),
    .o_ALUSrcA(alu_src_a[0]), .o_MulDiv(mul_div[0]), .o_funct3(funct3[0]), .o_funct7b5(funct7b5[0]),
    .o_rd(rd[0]), .o_rs1(rs1[0]), .o_rs2(rs2[0]), .o_pc(pc_out[0]), .o_illegal(illegal[0]),
    .o_halted(halted[0]), .o_illegal_cnt(cnt0)
  );

  decode_ctrl_stage #(.EN_MEXT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in), .o_ready(o_ready[1]), .i_instr(instr),
    .i_pc(pc), .i_ready(ready_in), .i_flush(flush), .o_valid(o_valid[1]),
    .o_RegWrite(reg_write[1]), .o_MemWrite(mem_write[1]), .o_Branch(branch[1]), .o_Jump(jump[1]),
    .o_ALUSrc(alu_src[1]), .o_ResultSrc(result_src[1]), .o_ImmSrc(imm_src[1]), .o_ALUOp(alu_op[1]),
    .o_ALUSrcA(alu_src_a[1]), .o_MulDiv(mul_div[1]), .o_funct3(funct3[1]), .o_funct7b5(funct7b5[1]),
    .o_rd(rd[1]), .o_rs1(rs1[1]), .o_rs2(rs2[1]), .o_pc(pc_out[1]), .o_illegal(illegal[1]),
    .o_halted(halted[1]), .o_illegal_cnt(cnt1)
  );

  decode_ctrl_stage #(.HALT_ON_ILLEGAL(0), .CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in), .o_ready(o_ready[2]), .i_instr(instr),
    .i_pc(pc), .i_ready(ready_in), .i_flush(flush), .o_valid(o_valid[2]),
    .o_RegWrite(reg_write[2]), .o_MemWrite(mem_write[2]), .o_Branch(branch[2]), .o_Jump(jump[2]),
    .o_ALUSrc(alu_src[2]), .o_ResultSrc(result_src[2]), .o_ImmSrc(imm_src[2]), .o_ALUOp(alu_op[2]),
    .o_ALUSrcA(alu_src_a[2]), .o_MulDiv(mul_div[2]), .o_funct3(funct3[2]), .o_funct7b5(funct7b5[2]),
    .o_rd(rd[2]), .o_rs1(rs1[2]), .o_rs2(rs2[2]), .o_pc(pc_out[2]), .o_illegal(illegal[2]),
    .o_halted(halted[2]), .o_illegal_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ill_words[5];
  logic [1:0]  cnt_exp[5];

  initial begin
    ill_words[0] = 32'hFFFF_FFFF;  // unknown opcode
    ill_words[1] = 32'h0000_0000;  // low bits not 11
    ill_words[2] = 32'h4000_1033;  // R-type funct7=0100000 with funct3=001
    ill_words[3] = 32'h0000_3003;  // load funct3=011
    ill_words[4] = 32'h0200_1013;  // slli with non-zero funct7
    cnt_exp[0] = 2'd1; cnt_exp[1] = 2'd2; cnt_exp[2] = 2'd3; cnt_exp[3] = 2'd3; cnt_exp[4] = 2'd3;

    rst_n = 1'b0; valid_in = 1'b0; instr = '0; pc = '0; ready_in = 1'b0; flush = 1'b0;
    #12;
    chk("rst_valid",  {31'd0, o_valid[0]}, 32'd0);
    chk("rst_cnt",    {24'd0, cnt0}, 32'd0);
    chk("rst_halted", {31'd0, halted[0]}, 32'd0);
    chk("rst_ready",  {31'd0, o_ready[0]}, 32'd1);
    rst_n = 1'b1;

    // lw x5,8(x2)
    valid_in = 1'b1; instr = 32'h0081_2283; pc = 32'h100; ready_in = 1'b1;
    step();
    chk("lw_valid",     {31'd0, o_valid[0]}, 32'd1);
    chk("lw_regwrite",  {31'd0, reg_write[0]}, 32'd1);
    chk("lw_resultsrc", {30'd0, result_src[0]}, 32'd1);
    chk("lw_alusrc",    {31'd0, alu_src[0]}, 32'd1);
    chk("lw_immsrc",    {29'd0, imm_src[0]}, 32'd0);
    chk("lw_aluop",     {30'd0, alu_op[0]}, 32'd0);
    chk("lw_rd",        {27'd0, rd[0]}, 32'd5);
    chk("lw_illegal",   {31'd0, illegal[0]}, 32'd0);
    chk("lw_pc",        pc_out[0], 32'h100);
    valid_in = 1'b0;
    step();
    chk("lw_drain", {31'd0, o_valid[0]}, 32'd0);

    // addi x6,x0,1 then add x7,x5,x6 under backpressure
    ready_in = 1'b0; valid_in = 1'b1; instr = 32'h0010_0313; pc = 32'h104;
    step();
    chk("addi_valid", {31'd0, o_valid[0]}, 32'd1);
    chk("addi_rd",    {27'd0, rd[0]}, 32'd6);
    chk("addi_aluop", {30'd0, alu_op[0]}, 32'd2);
    chk("bp_ready",   {31'd0, o_ready[0]}, 32'd0);
    instr = 32'h0062_83B3; pc = 32'h108;
    step();
    chk("hold_rd",    {27'd0, rd[0]}, 32'd6);
    chk("hold_pc",    pc_out[0], 32'h104);
    chk("hold_valid", {31'd0, o_valid[0]}, 32'd1);
    ready_in = 1'b1;
    #1;
    chk("release_ready", {31'd0, o_ready[0]}, 32'd1);
    step();
    chk("add_valid",  {31'd0, o_valid[0]}, 32'd1);
    chk("add_rd",     {27'd0, rd[0]}, 32'd7);
    chk("add_alusrc", {31'd0, alu_src[0]}, 32'd0);
    chk("add_pc",     pc_out[0], 32'h108);
    valid_in = 1'b0;
    step();
    chk("add_nodup", {31'd0, o_valid[0]}, 32'd0);

    // mul x1,x2,x3: illegal without M, legal with M
    valid_in = 1'b1; instr = 32'h0231_00B3; pc = 32'h10C;
    step();
    chk("mul0_illegal",  {31'd0, illegal[0]}, 32'd1);
    chk("mul0_regwrite", {31'd0, reg_write[0]}, 32'd0);
    chk("mul0_cnt",      {24'd0, cnt0}, 32'd1);
    chk("mul0_halted",   {31'd0, halted[0]}, 32'd1);
    chk("mul0_ready",    {31'd0, o_ready[0]}, 32'd0);
    chk("mul1_illegal",  {31'd0, illegal[1]}, 32'd0);
    chk("mul1_muldiv",   {31'd0, mul_div[1]}, 32'd1);
    chk("mul1_regwrite", {31'd0, reg_write[1]}, 32'd1);
    chk("mul1_halted",   {31'd0, halted[1]}, 32'd0);
    valid_in = 1'b0;
    step();
    chk("halt_drain",  {31'd0, o_valid[0]}, 32'd0);
    chk("halt_stays",  {31'd0, halted[0]}, 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    chk("flush_run",   {31'd0, halted[0]}, 32'd0);
    chk("flush_ready", {31'd0, o_ready[0]}, 32'd1);
    chk("flush_valid", {31'd0, o_valid[0]}, 32'd0);

    // flush together with an accept of an illegal word
    valid_in = 1'b1; flush = 1'b1; instr = 32'hFFFF_FFFF;
    step();
    chk("fa_valid",  {31'd0, o_valid[0]}, 32'd0);
    chk("fa_cnt",    {24'd0, cnt0}, 32'd1);
    chk("fa_halted", {31'd0, halted[0]}, 32'd0);
    valid_in = 1'b0; flush = 1'b0;

    // fresh reset, then saturating counter on the no-halt instance
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    valid_in = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr = ill_words[i];
      step();
      chk($sformatf("sat_cnt%0d", i),     {30'd0, cnt2}, {30'd0, cnt_exp[i]});
      chk($sformatf("sat_ready%0d", i),   {31'd0, o_ready[2]}, 32'd1);
      chk($sformatf("sat_illegal%0d", i), {31'd0, illegal[2]}, 32'd1);
    end

    // lui x0,0x12345
    instr = 32'h1234_5037;
    step();
    chk("lui_regwrite", {31'd0, reg_write[2]}, 32'd0);
    chk("lui_srca",     {30'd0, alu_src_a[2]}, 32'd2);
    chk("lui_immsrc",   {29'd0, imm_src[2]}, 32'd4);
    chk("lui_illegal",  {31'd0, illegal[2]}, 32'd0);
    chk("lui_valid",    {31'd0, o_valid[2]}, 32'd1);
    chk("lui_cnt",      {30'd0, cnt2}, 32'd3);

    // asynchronous reset mid-cycle while a bundle is held
    valid_in = 1'b0; ready_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  {31'd0, o_valid[2]}, 32'd0);
    chk("arst_srca",   {30'd0, alu_src_a[2]}, 32'd0);
    chk("arst_immsrc", {29'd0, imm_src[2]}, 32'd0);
    chk("arst_alusrc", {31'd0, alu_src[2]}, 32'd0);
    chk("arst_cnt",    {30'd0, cnt2}, 32'd0);
    chk("arst_pc",     pc_out[2], 32'd0);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
